// File: rtl/jk_drive_pkg.sv
// rtl/jk_drive_pkg.sv - shared encodings and parameter helpers for the J/K drive front end
package jk_drive_pkg;

    typedef enum logic {
        A_IDLE = 1'b0,
        A_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        PEND_SET = 1'b0,
        PEND_CLR = 1'b1
    } pend_e;

    // True when the parameter set describes a buildable configuration.
    function automatic bit params_legal(input int sync_stages, input int debounce_cycles,
                                        input int pair_window);
        return (sync_stages >= 2) && (debounce_cycles >= 1) && (pair_window >= 0);
    endfunction

    // Bits needed to hold 0..maxval, never less than one bit.
    function automatic int width_of(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/jk_debounce_ch.sv
// rtl/jk_debounce_ch.sv - one button channel: synchroniser, debouncer, rise pulse
module jk_debounce_ch
    import jk_drive_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic RAW,
    output logic DB,
    output logic RISE
);

    localparam int CW = width_of(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   db_q;
    logic                   db_d;
    logic                   db_dly_q;
    logic                   sync_x;

    assign sync_x = sync_q[SYNC_STAGES-1];

    // Shift the raw level in; count cycles the synced level disagrees with DB and flip on the last.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], RAW};
        cnt_d  = cnt_q;
        db_d   = db_q;
        if (sync_x == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            db_d  = ~db_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Channel state registers; the delayed DB copy feeds the rise detector.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_q;
        end
    end

    assign DB   = db_q;
    assign RISE = db_q & ~db_dly_q;

endmodule

// File: rtl/jk_drive_debounce.sv
// rtl/jk_drive_debounce.sv - debounced SET/CLR buttons paired into J/K command pulses
module jk_drive_debounce
    import jk_drive_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PAIR_WINDOW     = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic SET_RAW,
    input  logic CLR_RAW,
    output logic SET_DB,
    output logic CLR_DB,
    output logic J,
    output logic K
);

    localparam int TW = width_of(PAIR_WINDOW);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(PAIR_WINDOW);

    if (!params_legal(SYNC_STAGES, DEBOUNCE_CYCLES, PAIR_WINDOW)) begin : g_illegal_params
        $error("jk_drive_debounce: illegal parameter set");
    end

    logic       set_rise;
    logic       clr_rise;
    logic       partner_rise;
    arb_state_e state_q;
    arb_state_e state_d;
    pend_e      pend_q;
    pend_e      pend_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic       j_q;
    logic       j_d;
    logic       k_q;
    logic       k_d;

    jk_debounce_ch #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_set_ch (
        .CLK (CLK),
        .RST (RST),
        .RAW (SET_RAW),
        .DB  (SET_DB),
        .RISE(set_rise)
    );

    jk_debounce_ch #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr_ch (
        .CLK (CLK),
        .RST (RST),
        .RAW (CLR_RAW),
        .DB  (CLR_DB),
        .RISE(clr_rise)
    );

    assign partner_rise = (pend_q == PEND_SET) ? clr_rise : set_rise;

    // Pairing arbiter: hold a lone press for the window, merge with a partner into a toggle.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        timer_d = timer_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        case (state_q)
            A_IDLE: begin
                if (set_rise && clr_rise) begin
                    j_d = 1'b1;
                    k_d = 1'b1;
                end else if (set_rise || clr_rise) begin
                    if (PAIR_WINDOW == 0) begin
                        j_d = set_rise;
                        k_d = clr_rise;
                    end else begin
                        pend_d  = set_rise ? PEND_SET : PEND_CLR;
                        timer_d = TIMER_LOAD;
                        state_d = A_WAIT;
                    end
                end
            end
            A_WAIT: begin
                if (partner_rise) begin
                    j_d     = 1'b1;
                    k_d     = 1'b1;
                    state_d = A_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                    if (timer_d == '0) begin
                        j_d     = (pend_q == PEND_SET);
                        k_d     = (pend_q == PEND_CLR);
                        state_d = A_IDLE;
                    end
                end
            end
            default: state_d = A_IDLE;
        endcase
    end

    // Arbiter state and the registered J/K command outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= A_IDLE;
            pend_q  <= PEND_SET;
            timer_q <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    assign J = j_q;
    assign K = k_q;

endmodule

// File: tb/tb_jk_drive_debounce.sv
// tb/tb_jk_drive_debounce.sv - randomized and directed checks of jk_drive_debounce against a behavioural model
module tb_jk_drive_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int PW   = 2;
    localparam int MAXE = 8192;

    logic CLK = 1'b0;
    logic RST;
    logic SET_RAW;
    logic CLR_RAW;
    logic SET_DB;
    logic CLR_DB;
    logic J;
    logic K;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    bit raw_h  [2][MAXE];
    bit rise_h [2][MAXE];
    bit mdb    [2];
    int last_flip [2];
    int n       = 0;
    int pend_ch = -1;
    int t0      = 0;
    bit ej      = 1'b0;
    bit ek      = 1'b0;

    jk_drive_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .PAIR_WINDOW    (PW)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SET_RAW(SET_RAW),
        .CLR_RAW(CLR_RAW),
        .SET_DB (SET_DB),
        .CLR_DB (CLR_DB),
        .J      (J),
        .K      (K)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Model of one clock edge, from the rules: synced level is the raw sample SYNC edges old,
    // DB flips once DEB consecutive synced samples (all since the last flip) disagree with it,
    // lone rises fire PW+1 edges later unless a partner rise arrives within the window.
    task automatic model_edge(input bit rst, input bit s_raw, input bit c_raw);
        bit raw [2];
        bit prev;
        bit all_diff;
        bit v;
        bit rs;
        bit rc;
        int c;
        n++;
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                raw_h[ch][n]  = 1'b0;
                rise_h[ch][n] = 1'b0;
                mdb[ch]       = 1'b0;
                last_flip[ch] = n;
            end
            pend_ch = -1;
            ej = 1'b0;
            ek = 1'b0;
            return;
        end
        c  = n - 1;
        rs = rise_h[0][c];
        rc = rise_h[1][c];
        ej = 1'b0;
        ek = 1'b0;
        if (pend_ch < 0) begin
            if (rs && rc) begin
                ej = 1'b1;
                ek = 1'b1;
            end else if (rs || rc) begin
                if (PW == 0) begin
                    ej = rs;
                    ek = rc;
                end else begin
                    pend_ch = rs ? 0 : 1;
                    t0      = c;
                end
            end
        end else begin
            if ((pend_ch == 0) ? rc : rs) begin
                ej = 1'b1;
                ek = 1'b1;
                pend_ch = -1;
            end else if (c == t0 + PW) begin
                ej = (pend_ch == 0);
                ek = (pend_ch == 1);
                pend_ch = -1;
            end
        end
        raw[0] = s_raw;
        raw[1] = c_raw;
        for (int ch = 0; ch < 2; ch++) begin
            raw_h[ch][n] = raw[ch];
            prev = mdb[ch];
            if (n - last_flip[ch] >= DEB) begin
                all_diff = 1'b1;
                for (int k = n - DEB + 1; k <= n; k++) begin
                    v = (k - SYNC >= 0) ? raw_h[ch][k-SYNC] : 1'b0;
                    if (v == mdb[ch]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    mdb[ch]       = ~mdb[ch];
                    last_flip[ch] = n;
                end
            end
            rise_h[ch][n] = mdb[ch] & ~prev;
        end
    endtask

    // One clock: advance the model on the edge, then compare every output 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        model_edge(RST, SET_RAW, CLR_RAW);
        #1;
        check("set_db", {31'd0, SET_DB}, {31'd0, mdb[0]});
        check("clr_db", {31'd0, CLR_DB}, {31'd0, mdb[1]});
        check("j", {31'd0, J}, {31'd0, ej});
        check("k", {31'd0, K}, {31'd0, ek});
    endtask

    task automatic ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    task automatic async_reset_pulse();
        RST = 1'b1;
        #1;
        check("async_rst_outs", {28'd0, SET_DB, CLR_DB, J, K}, 32'd0);
        tick();
        RST = 1'b0;
    endtask

    initial begin
        int lone_j;
        int lone_k;
        int pair;
        int cnt_s;
        int cnt_c;

        // 1. reset with both buttons held
        RST = 1'b1;
        SET_RAW = 1'b1;
        CLR_RAW = 1'b1;
        tick();
        check("reset_outs", {28'd0, SET_DB, CLR_DB, J, K}, 32'd0);
        RST = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 5) check("t1_db_not_yet", {30'd0, SET_DB, CLR_DB}, 32'd0);
            if (i == 6) check("t1_db_edge6", {28'd0, SET_DB, CLR_DB, J, K}, 32'hC);
            if (i == 7) check("t1_toggle", {30'd0, J, K}, 32'h3);
        end
        SET_RAW = 1'b0;
        CLR_RAW = 1'b0;
        ticks(10);

        // 2. glitch of 3 cycles
        SET_RAW = 1'b1;
        ticks(3);
        SET_RAW = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t2_glitch", {30'd0, SET_DB, J}, 32'd0);
        end

        // 3. clean set and release
        SET_RAW = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 6) check("t3_set_db", {31'd0, SET_DB}, 32'd1);
            if (i == 9) check("t3_lone_j", {30'd0, J, K}, 32'h2);
            else check("t3_quiet", {30'd0, J, K}, 32'd0);
        end
        SET_RAW = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) check("t3_rel_hold", {31'd0, SET_DB}, 32'd1);
            if (i == 6) check("t3_rel_db", {31'd0, SET_DB}, 32'd0);
            check("t3_rel_quiet", {30'd0, J, K}, 32'd0);
        end
        ticks(4);

        // 4. pair within window
        lone_j = 0; lone_k = 0; pair = 0;
        SET_RAW = 1'b1;
        tick();
        CLR_RAW = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (J && K) pair++;
            if (J && !K) lone_j++;
            if (K && !J) lone_k++;
            if (i == 7) check("t4_pair_at", {30'd0, J, K}, 32'h3);
        end
        check("t4_pair_cnt", pair, 1);
        check("t4_lone_cnt", lone_j + lone_k, 0);
        SET_RAW = 1'b0;
        CLR_RAW = 1'b0;
        ticks(10);

        // 5. partner outside window
        lone_j = 0; lone_k = 0; pair = 0;
        SET_RAW = 1'b1;
        ticks(5);
        CLR_RAW = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (J && K) pair++;
            if (J && !K) lone_j++;
            if (K && !J) lone_k++;
            if (i == 9) check("t5_lone_k", {30'd0, J, K}, 32'h1);
        end
        check("t5_counts", {lone_j[7:0], lone_k[7:0], pair[7:0]}, 32'h010100);
        SET_RAW = 1'b0;
        CLR_RAW = 1'b0;
        ticks(10);

        // 6. reset while a lone SET is pending
        SET_RAW = 1'b1;
        ticks(7);
        SET_RAW = 1'b0;
        async_reset_pulse();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t6_no_j", {31'd0, J}, 32'd0);
        end
        CLR_RAW = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 9) check("t6_idle_k", {30'd0, J, K}, 32'h1);
        end
        CLR_RAW = 1'b0;
        ticks(10);

        // randomized bouncing buttons with occasional resets
        cnt_s = $urandom_range(1, 12);
        cnt_c = $urandom_range(1, 12);
        for (int t = 0; t < 3000; t++) begin
            cnt_s--;
            cnt_c--;
            if (cnt_s == 0) begin
                SET_RAW = ~SET_RAW;
                cnt_s = $urandom_range(1, 12);
            end
            if (cnt_c == 0) begin
                CLR_RAW = ~CLR_RAW;
                cnt_c = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 599) == 0) async_reset_pulse();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
